// File: rtl/parallel_cmd_responder.sv
// Byte-wide command responder for the Pi parallel link. The block decodes an axis
// request, waits for an accelerometer sample (or a timeout) and returns it as two
// bytes, low byte first, each advanced by a Pi strobe.
module parallel_cmd_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK_50,
  input  logic       dly_rst,
  input  logic       rp_clk_in,
  input  logic       rp_cs_n,
  input  logic [7:0] rp_data_in,
  output logic [7:0] rp_data_out,
  output logic       rp_data_oe,
  output logic       rp_ready,
  output logic [1:0] acc_dim,
  input  logic [7:0] acc_data_l,
  input  logic [7:0] acc_data_h,
  input  logic       acc_valid,
  output logic [7:0] err_count,
  output logic       timeout_flag
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWaitSample, StSendL, StSendH} state_e;

  state_e          state_q, state_d;
  logic [15:0]     hold_q, hold_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      dim_d;
  logic [7:0]      err_d;
  logic            flag_d;
  logic [7:0]      data_out_d;
  logic            oe_d, ready_d;
  logic            err_inc;

  logic       clk_s1, clk_s2, clk_s3;
  logic       cs_s1, cs_s2;
  logic [7:0] data_s1, data_s2;
  logic       strobe_edge, cs_active;

  // Two-flop synchronizers; the third strobe flop feeds the rising-edge detector.
  always_ff @(posedge CLK_50) begin
    if (dly_rst) begin
      clk_s1  <= 1'b0;
      clk_s2  <= 1'b0;
      clk_s3  <= 1'b0;
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      data_s1 <= 8'h00;
      data_s2 <= 8'h00;
    end else begin
      clk_s1  <= rp_clk_in;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      cs_s1   <= rp_cs_n;
      cs_s2   <= cs_s1;
      data_s1 <= rp_data_in;
      data_s2 <= data_s1;
    end
  end

  assign strobe_edge = clk_s2 & ~clk_s3;
  assign cs_active   = ~cs_s2;

  // Protocol state, sample hold, timeout counter and registered outputs.
  always_ff @(posedge CLK_50) begin
    if (dly_rst) begin
      state_q      <= StIdle;
      hold_q       <= 16'h0000;
      cnt_q        <= '0;
      acc_dim      <= 2'd0;
      err_count    <= 8'h00;
      timeout_flag <= 1'b0;
      rp_data_out  <= 8'h00;
      rp_data_oe   <= 1'b0;
      rp_ready     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      acc_dim      <= dim_d;
      err_count    <= err_d;
      timeout_flag <= flag_d;
      rp_data_out  <= data_out_d;
      rp_data_oe   <= oe_d;
      rp_ready     <= ready_d;
    end
  end

  // Next-state decode; outputs are derived from the next state so they are registered.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    dim_d      = acc_dim;
    err_d      = err_count;
    flag_d     = timeout_flag;
    err_inc    = 1'b0;
    data_out_d = 8'h00;
    oe_d       = 1'b0;
    ready_d    = 1'b0;

    if (!cs_active) begin
      // Deselect aborts any transaction; strobes while deselected are not errors.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (strobe_edge) begin
            case (data_s2)
              8'h78: begin dim_d = 2'd0; cnt_d = '0; state_d = StWaitSample; end
              8'h79: begin dim_d = 2'd1; cnt_d = '0; state_d = StWaitSample; end
              8'h7A: begin dim_d = 2'd2; cnt_d = '0; state_d = StWaitSample; end
              default: err_inc = 1'b1;
            endcase
          end
        end
        StWaitSample: begin
          cnt_d = cnt_q + 1'b1;
          if (strobe_edge) err_inc = 1'b1;
          // A real sample wins over a coincident timeout.
          if (acc_valid) begin
            hold_d  = {acc_data_h, acc_data_l};
            state_d = StSendL;
          end else if (cnt_q == CntLast) begin
            hold_d  = 16'h8000;
            flag_d  = 1'b1;
            state_d = StSendL;
          end
        end
        StSendL: if (strobe_edge) state_d = StSendH;
        StSendH: if (strobe_edge) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    if (err_inc && (err_count != 8'hFF)) err_d = err_count + 8'h01;

    case (state_d)
      StSendL: begin data_out_d = hold_d[7:0];  oe_d = 1'b1; ready_d = 1'b1; end
      StSendH: begin data_out_d = hold_d[15:8]; oe_d = 1'b1; ready_d = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_parallel_cmd_responder.sv
// Directed bench for parallel_cmd_responder with a short timeout.
module tb_parallel_cmd_responder;

  logic       CLK_50 = 1'b0;
  logic       dly_rst = 1'b1;
  logic       rp_clk_in = 1'b0;
  logic       rp_cs_n = 1'b0;
  logic [7:0] rp_data_in = 8'h00;
  logic [7:0] rp_data_out;
  logic       rp_data_oe;
  logic       rp_ready;
  logic [1:0] acc_dim;
  logic [7:0] acc_data_l = 8'h00;
  logic [7:0] acc_data_h = 8'h00;
  logic       acc_valid = 1'b0;
  logic [7:0] err_count;
  logic       timeout_flag;

  int n_total = 0;
  int n_pass  = 0;

  parallel_cmd_responder #(.TIMEOUT_CYCLES(16)) dut (
    .CLK_50      (CLK_50),
    .dly_rst     (dly_rst),
    .rp_clk_in   (rp_clk_in),
    .rp_cs_n     (rp_cs_n),
    .rp_data_in  (rp_data_in),
    .rp_data_out (rp_data_out),
    .rp_data_oe  (rp_data_oe),
    .rp_ready    (rp_ready),
    .acc_dim     (acc_dim),
    .acc_data_l  (acc_data_l),
    .acc_data_h  (acc_data_h),
    .acc_valid   (acc_valid),
    .err_count   (err_count),
    .timeout_flag(timeout_flag)
  );

  always #10 CLK_50 = ~CLK_50;

  // Advance n rising edges and land 1 ns after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge CLK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One Pi strobe: 4 cycles high, 4 low; the DUT acts 3 edges after the rise.
  task automatic strobe(input logic [7:0] b);
    rp_data_in = b;
    rp_clk_in  = 1'b1;
    step(4);
    rp_clk_in  = 1'b0;
    step(4);
  endtask

  task automatic sample(input logic [7:0] h, input logic [7:0] l);
    acc_data_h = h;
    acc_data_l = l;
    acc_valid  = 1'b1;
    step(1);
    acc_valid  = 1'b0;
  endtask

  initial begin
    // Reset values
    step(3);
    check("rst_data", {8'h0, rp_data_out}, 16'h0000);
    check("rst_oe", {15'h0, rp_data_oe}, 16'h0000);
    check("rst_ready", {15'h0, rp_ready}, 16'h0000);
    check("rst_dim", {14'h0, acc_dim}, 16'h0000);
    check("rst_err", {8'h0, err_count}, 16'h0000);
    check("rst_flag", {15'h0, timeout_flag}, 16'h0000);
    dly_rst = 1'b0;
    step(3);

    // Y-axis read: low byte then high byte
    strobe(8'h79);
    check("y_dim", {14'h0, acc_dim}, 16'h0001);
    check("y_wait_oe", {15'h0, rp_data_oe}, 16'h0000);
    sample(8'h12, 8'h34);
    check("y_low", {8'h0, rp_data_out}, 16'h0034);
    check("y_low_oe", {15'h0, rp_data_oe}, 16'h0001);
    check("y_low_ready", {15'h0, rp_ready}, 16'h0001);
    strobe(8'h00);
    check("y_high", {8'h0, rp_data_out}, 16'h0012);
    check("y_high_oe", {15'h0, rp_data_oe}, 16'h0001);
    strobe(8'h00);
    check("y_done_oe", {15'h0, rp_data_oe}, 16'h0000);
    check("y_done_ready", {15'h0, rp_ready}, 16'h0000);
    check("y_err", {8'h0, err_count}, 16'h0000);

    // X-axis read; a strobe while waiting is an error; sample coincides with terminal count
    strobe(8'h78);
    strobe(8'h41);
    check("wait_edge_err", {8'h0, err_count}, 16'h0001);
    check("wait_edge_oe", {15'h0, rp_data_oe}, 16'h0000);
    step(2);
    check("pre_term_oe", {15'h0, rp_data_oe}, 16'h0000);
    sample(8'hAB, 8'hCD);
    check("coin_low", {8'h0, rp_data_out}, 16'h00CD);
    check("coin_oe", {15'h0, rp_data_oe}, 16'h0001);
    check("coin_flag", {15'h0, timeout_flag}, 16'h0000);
    check("coin_dim", {14'h0, acc_dim}, 16'h0000);
    strobe(8'h00);
    check("coin_high", {8'h0, rp_data_out}, 16'h00AB);
    strobe(8'h00);
    check("coin_done_oe", {15'h0, rp_data_oe}, 16'h0000);

    // Bad command in IDLE, stray sample ignored, error count saturates
    strobe(8'h41);
    check("bad_err", {8'h0, err_count}, 16'h0002);
    check("bad_oe", {15'h0, rp_data_oe}, 16'h0000);
    sample(8'h55, 8'h66);
    step(2);
    check("stray_valid_oe", {15'h0, rp_data_oe}, 16'h0000);
    for (int i = 0; i < 300; i++) strobe(8'h41);
    check("err_sat", {8'h0, err_count}, 16'h00FF);

    // Z-axis timeout: SEND_L lands exactly 16 cycles into the wait
    strobe(8'h7A);
    check("z_dim", {14'h0, acc_dim}, 16'h0002);
    step(10);
    check("z_pre_to_oe", {15'h0, rp_data_oe}, 16'h0000);
    check("z_pre_to_flag", {15'h0, timeout_flag}, 16'h0000);
    step(1);
    check("z_to_low", {8'h0, rp_data_out}, 16'h0000);
    check("z_to_oe", {15'h0, rp_data_oe}, 16'h0001);
    check("z_to_flag", {15'h0, timeout_flag}, 16'h0001);
    strobe(8'h00);
    check("z_to_high", {8'h0, rp_data_out}, 16'h0080);
    strobe(8'h00);
    check("z_done_oe", {15'h0, rp_data_oe}, 16'h0000);
    check("z_flag_sticky", {15'h0, timeout_flag}, 16'h0001);

    // Deselect during SEND_L aborts; next command works
    strobe(8'h79);
    sample(8'h55, 8'h66);
    check("abort_low", {8'h0, rp_data_out}, 16'h0066);
    rp_cs_n = 1'b1;
    step(2);
    check("abort_oe_hold", {15'h0, rp_data_oe}, 16'h0001);
    step(1);
    check("abort_oe", {15'h0, rp_data_oe}, 16'h0000);
    check("abort_ready", {15'h0, rp_ready}, 16'h0000);
    rp_cs_n = 1'b0;
    step(3);
    strobe(8'h78);
    check("retry_dim", {14'h0, acc_dim}, 16'h0000);
    sample(8'h9A, 8'hBC);
    check("retry_low", {8'h0, rp_data_out}, 16'h00BC);
    strobe(8'h00);
    check("retry_high", {8'h0, rp_data_out}, 16'h009A);

    // Reset while in SEND_H
    dly_rst = 1'b1;
    step(1);
    check("mid_rst_data", {8'h0, rp_data_out}, 16'h0000);
    check("mid_rst_oe", {15'h0, rp_data_oe}, 16'h0000);
    check("mid_rst_ready", {15'h0, rp_ready}, 16'h0000);
    check("mid_rst_err", {8'h0, err_count}, 16'h0000);
    check("mid_rst_flag", {15'h0, timeout_flag}, 16'h0000);
    check("mid_rst_dim", {14'h0, acc_dim}, 16'h0000);
    dly_rst = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
